// File: rtl/boreal_spi_frame_writer_pkg.sv
// ==== boreal_spi_pkg : shared FSM states, CRC-8 constants and bit-serial CRC update (rev 1.0) ====
`default_nettype none

package boreal_spi_pkg;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    HDR     = 3'd1,
    PAY     = 3'd2,
    CRC     = 3'd3,
    COMMIT  = 3'd4,
    WAIT_CS = 3'd5
  } state_e;

  localparam logic [7:0] CRC8_POLY         = 8'h07;
  localparam logic [7:0] DEFAULT_SYNC_BYTE = 8'hA5;

  function automatic logic [7:0] crc8_bit(input logic [7:0] crc, input logic b);
    return {crc[6:0], 1'b0} ^ ((crc[7] ^ b) ? CRC8_POLY : 8'h00);
  endfunction

endpackage

`default_nettype wire

// File: rtl/boreal_spi_frame_writer_if.sv
// ==== boreal_spi_frame_writer_if : write port of the dual-clock payload FIFO (rev 1.0) ====
`default_nettype none

interface boreal_spi_frame_writer_if #(
  parameter int DATA_WIDTH = 792
);
  logic                  wr_en;
  logic [DATA_WIDTH-1:0] din;
  logic                  full;

  modport master (output wr_en, output din, input full);
  modport slave  (input wr_en, input din, output full);
endinterface

`default_nettype wire

// File: rtl/boreal_spi_frame_writer_sync_edge.sv
// ==== boreal_spi_sync_edge : 2-FF synchroniser, third stage and edge pulses (rev 1.0) ====
`default_nettype none

module boreal_spi_sync_edge #(
  parameter logic RST_VAL = 1'b0
) (
  input  wire logic wr_clk,
  input  wire logic wr_rst_n,
  input  wire logic async_i,
  output logic      level_o,
  output logic      rise_o,
  output logic      fall_o
);

  logic [2:0] stg_q;

  always_ff @(posedge wr_clk or negedge wr_rst_n) begin
    if (!wr_rst_n) stg_q <= {3{RST_VAL}};
    else           stg_q <= {stg_q[1:0], async_i};
  end

  assign level_o = stg_q[1];
  assign rise_o  = stg_q[1] & ~stg_q[2];
  assign fall_o  = ~stg_q[1] & stg_q[2];

endmodule

`default_nettype wire

// File: rtl/boreal_spi_frame_writer.sv
// ==== boreal_spi_frame_writer : SPI-slave frame deserializer feeding the payload FIFO (rev 1.0) ====
`default_nettype none

module boreal_spi_frame_writer
  import boreal_spi_pkg::*;
#(
  parameter int          DATA_WIDTH = 792,
  parameter logic [7:0]  SYNC_BYTE  = DEFAULT_SYNC_BYTE,
  parameter int          CNT_WIDTH  = 16
) (
  input  wire logic                 wr_clk,
  input  wire logic                 wr_rst_n,
  input  wire logic                 spi_sclk,
  input  wire logic                 spi_cs_n,
  input  wire logic                 spi_mosi,
  boreal_spi_frame_writer_if.master fifo,
  output logic                      busy,
  output logic [CNT_WIDTH-1:0]      frame_ok_cnt,
  output logic [CNT_WIDTH-1:0]      crc_err_cnt,
  output logic [CNT_WIDTH-1:0]      sync_err_cnt,
  output logic [CNT_WIDTH-1:0]      overflow_cnt,
  output logic [CNT_WIDTH-1:0]      abort_cnt
);

  localparam int BW = $clog2(DATA_WIDTH + 1);

  if (DATA_WIDTH % 8 != 0) begin : g_width_check
    $error("boreal_spi_frame_writer: DATA_WIDTH must be a multiple of 8");
  end

  logic sclk_lvl, sclk_rise, sclk_fall;
  logic cs_lvl, cs_rise, cs_fall;
  logic mosi_lvl, mosi_rise, mosi_fall;
  logic sync_unused;

  boreal_spi_sync_edge #(.RST_VAL(1'b0)) u_sync_sclk (
    .wr_clk(wr_clk), .wr_rst_n(wr_rst_n), .async_i(spi_sclk),
    .level_o(sclk_lvl), .rise_o(sclk_rise), .fall_o(sclk_fall));
  boreal_spi_sync_edge #(.RST_VAL(1'b1)) u_sync_cs (
    .wr_clk(wr_clk), .wr_rst_n(wr_rst_n), .async_i(spi_cs_n),
    .level_o(cs_lvl), .rise_o(cs_rise), .fall_o(cs_fall));
  boreal_spi_sync_edge #(.RST_VAL(1'b0)) u_sync_mosi (
    .wr_clk(wr_clk), .wr_rst_n(wr_rst_n), .async_i(spi_mosi),
    .level_o(mosi_lvl), .rise_o(mosi_rise), .fall_o(mosi_fall));

  assign sync_unused = &{sclk_lvl, sclk_fall, mosi_rise, mosi_fall};

  state_e                 state_q;
  logic [BW-1:0]          bit_cnt_q;
  logic [7:0]             shift_q;
  logic [7:0]             crc_q;
  logic [DATA_WIDTH-1:0]  din_q;
  logic                   crc_match_q;
  logic [1:0]             fill_q;
  logic                   armed_q;
  logic [CNT_WIDTH-1:0]   ok_q, crc_err_q, sync_err_q, ovf_q, abort_q;
  logic [7:0]             byte_w;

  function automatic logic [CNT_WIDTH-1:0] sat_inc(input logic [CNT_WIDTH-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

  assign byte_w = {shift_q[6:0], mosi_lvl};

  // armed_q only rises once the cs_n synchroniser holds a real high sample, so a
  // chip select already low at reset release never opens a frame.
  always_ff @(posedge wr_clk or negedge wr_rst_n) begin
    if (!wr_rst_n) begin
      state_q     <= IDLE;
      bit_cnt_q   <= '0;
      shift_q     <= '0;
      crc_q       <= '0;
      din_q       <= '0;
      crc_match_q <= 1'b0;
      fill_q      <= '0;
      armed_q     <= 1'b0;
      ok_q        <= '0;
      crc_err_q   <= '0;
      sync_err_q  <= '0;
      ovf_q       <= '0;
      abort_q     <= '0;
    end else begin
      fill_q <= {fill_q[0], 1'b1};
      if (fill_q[1] && cs_lvl) armed_q <= 1'b1;
      unique case (state_q)
        IDLE: if (cs_fall && armed_q) begin
          state_q   <= HDR;
          bit_cnt_q <= '0;
          crc_q     <= '0;
        end
        HDR: if (cs_rise) begin
          abort_q <= sat_inc(abort_q);
          state_q <= IDLE;
        end else if (sclk_rise) begin
          shift_q <= byte_w;
          if (bit_cnt_q == BW'(7)) begin
            bit_cnt_q <= '0;
            if (byte_w == SYNC_BYTE) begin
              state_q <= PAY;
            end else begin
              sync_err_q <= sat_inc(sync_err_q);
              state_q    <= WAIT_CS;
            end
          end else begin
            bit_cnt_q <= bit_cnt_q + 1'b1;
          end
        end
        PAY: if (cs_rise) begin
          abort_q <= sat_inc(abort_q);
          state_q <= IDLE;
        end else if (sclk_rise) begin
          din_q <= {din_q[DATA_WIDTH-2:0], mosi_lvl};
          crc_q <= crc8_bit(crc_q, mosi_lvl);
          if (bit_cnt_q == BW'(DATA_WIDTH - 1)) begin
            bit_cnt_q <= '0;
            state_q   <= CRC;
          end else begin
            bit_cnt_q <= bit_cnt_q + 1'b1;
          end
        end
        // The last CRC bit is tested before cs_n rise so a simultaneous rise still commits.
        CRC: if (sclk_rise && bit_cnt_q == BW'(7)) begin
          crc_match_q <= (byte_w == crc_q);
          state_q     <= COMMIT;
        end else if (cs_rise) begin
          abort_q <= sat_inc(abort_q);
          state_q <= IDLE;
        end else if (sclk_rise) begin
          shift_q   <= byte_w;
          bit_cnt_q <= bit_cnt_q + 1'b1;
        end
        COMMIT: begin
          if (!crc_match_q)   crc_err_q <= sat_inc(crc_err_q);
          else if (fifo.full) ovf_q     <= sat_inc(ovf_q);
          else                ok_q      <= sat_inc(ok_q);
          state_q <= WAIT_CS;
        end
        // Level rather than edge, so a cs_n rise that landed during COMMIT is not lost.
        WAIT_CS: if (cs_lvl) state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

  // full is gated in the same cycle as wr_en so a write never lands on a full FIFO.
  assign fifo.wr_en   = (state_q == COMMIT) && crc_match_q && !fifo.full;
  assign fifo.din     = din_q;
  assign busy         = (state_q != IDLE);
  assign frame_ok_cnt = ok_q;
  assign crc_err_cnt  = crc_err_q;
  assign sync_err_cnt = sync_err_q;
  assign overflow_cnt = ovf_q;
  assign abort_cnt    = abort_q;

endmodule

`default_nettype wire
